// File: rtl/chart_sequencer_pkg.sv
// Shared types and constants for the chart sequencer.
// Chart entries are {arrows, timing}; a timing of END_MARKER terminates the chart.
package chart_sequencer_pkg;

  localparam int ARROW_W  = 4;
  localparam int TIMING_W = 4;

  localparam logic [TIMING_W-1:0] END_MARKER = 4'd0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EMIT  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    SEQ_IDLE  = ST_IDLE,
    SEQ_FETCH = ST_FETCH,
    SEQ_EMIT  = ST_EMIT,
    SEQ_WAIT  = ST_WAIT,
    SEQ_DONE  = ST_DONE
  } seq_state_t;

endpackage

// File: rtl/chart_sequencer_counter_up.sv
// Free-running up counter with synchronous clear; used for tick and fetch-latency counting.
// Count updates one cycle after en_i; no backpressure, the owner bounds the range.
module counter_up #(
  parameter int W_P = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           clr_i,
  input  logic           en_i,
  output logic [W_P-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      count_o <= '0;
    end else if (en_i) begin
      count_o <= count_o + W_P'(1);
    end
  end

endmodule

// File: rtl/chart_sequencer.sv
// Steps through a chart in external sync RAM, emitting notes and waiting timing ticks per entry.
// Entry sampled FETCH_LAT_P cycles after next_o; ticks during FETCH/EMIT or with pause_i high are dropped.
module chart_sequencer
  import chart_sequencer_pkg::*;
#(
  parameter int FETCH_LAT_P = 2,
  parameter int NOTES_W_P   = 7
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 pause_i,
  input  logic                 tick_i,
  input  logic [ARROW_W-1:0]   arrows_i,
  input  logic [TIMING_W-1:0]  timing_i,
  output logic                 next_o,
  output logic                 note_valid_o,
  output logic [ARROW_W-1:0]   note_arrows_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [NOTES_W_P-1:0] note_count_o
);

  localparam int LAT_W = (FETCH_LAT_P > 1) ? $clog2(FETCH_LAT_P) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(FETCH_LAT_P - 1);

  seq_state_t            state_q;
  seq_state_t            state_d;
  logic [ARROW_W-1:0]    arrows_q;
  logic [TIMING_W-1:0]   timing_q;
  logic [TIMING_W-1:0]   tick_cnt;
  logic [TIMING_W-1:0]   tick_nxt;
  logic [LAT_W-1:0]      lat_cnt;
  logic [NOTES_W_P-1:0]  note_count_q;

  logic fetch_done;
  logic tick_hit;
  logic tick_last;
  logic emit_note;
  logic restart;

  assign fetch_done = (state_q == SEQ_FETCH) && (lat_cnt == LAT_LAST);
  assign tick_hit   = (state_q == SEQ_WAIT) && tick_i && !pause_i;
  assign tick_nxt   = tick_cnt + TIMING_W'(1);
  assign tick_last  = tick_hit && (tick_nxt == timing_q);
  assign emit_note  = (state_q == SEQ_EMIT) && (timing_q != END_MARKER) && (arrows_q != '0);
  assign restart    = (state_q == SEQ_DONE) && start_i;

  // Gated by reset so an abort never advances the externally owned chart address.
  assign next_o        = !reset_i && (tick_last || restart);
  assign note_valid_o  = emit_note;
  assign note_arrows_o = arrows_q;
  assign busy_o        = (state_q != SEQ_IDLE) && (state_q != SEQ_DONE);
  assign done_o        = (state_q == SEQ_DONE);
  assign note_count_o  = note_count_q;

  counter_up #(.W_P(TIMING_W)) u_tick_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (state_q != SEQ_WAIT),
    .en_i    (tick_hit),
    .count_o (tick_cnt)
  );

  counter_up #(.W_P(LAT_W)) u_lat_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (state_q != SEQ_FETCH),
    .en_i    (state_q == SEQ_FETCH),
    .count_o (lat_cnt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_IDLE:  if (start_i) state_d = SEQ_FETCH;
      SEQ_FETCH: if (fetch_done) state_d = SEQ_EMIT;
      SEQ_EMIT:  state_d = (timing_q == END_MARKER) ? SEQ_DONE : SEQ_WAIT;
      SEQ_WAIT:  if (tick_last) state_d = SEQ_FETCH;
      SEQ_DONE:  if (start_i) state_d = SEQ_FETCH;
      default:   state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= SEQ_IDLE;
      arrows_q     <= '0;
      timing_q     <= '0;
      note_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (fetch_done) begin
        arrows_q <= arrows_i;
        timing_q <= timing_i;
      end
      if ((state_q == SEQ_IDLE) || restart) begin
        note_count_q <= '0;
      end else if (emit_note && (note_count_q != '1)) begin
        note_count_q <= note_count_q + NOTES_W_P'(1);
      end
    end
  end

endmodule
